hydra_pkt_gen: RTL and testbench
================================

Name: hydra_pkt_gen

Overview:
- Synthesizable, parametrised multi-channel packet generator that drives the hydra write-side protocol: wr_sop, wr_vld, wr_data, wr_eop, with pause back-pressure.
- Replaces hand-sequenced stimulus. Each channel emits a programmable burst of packets with a {len, prio, dest} header word, then a deterministic payload.
- Used in simulation benches and in FPGA self-test ahead of the hydra write ports.

Parameters:
- NUM_PORTS, 16, number of independent generator channels
- DATA_WIDTH, 16, width of each wr_data lane
- LEN_WIDTH, 9, header length field; payload words per packet
- PRIO_WIDTH, 3, header priority field
- DEST_WIDTH, 4, header destination-port field
- CNT_WIDTH, 16, width of the per-command packet count
- GAP_WIDTH, 4, width of the inter-packet gap field
- Elaboration error unless LEN_WIDTH+PRIO_WIDTH+DEST_WIDTH == DATA_WIDTH and NUM_PORTS >= 1.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command accepted this cycle when cmd_vld & cmd_rdy
- cmd_port  in  $clog2(NUM_PORTS)  target channel
- cmd_dest  in  DEST_WIDTH  header dest
- cmd_prio  in  PRIO_WIDTH  header prio
- cmd_len  in  LEN_WIDTH  payload words per packet
- cmd_count  in  CNT_WIDTH  packets to send
- cmd_gap  in  GAP_WIDTH  idle cycles between eop and next sop
- cmd_mode  in  1  payload mode: 0 = word index, 1 = word index ^ (pkt_seq << DATA_WIDTH/2)
- abort  in  NUM_PORTS  per-channel stop request
- pause  in  NUM_PORTS  per-port back-pressure from hydra
- wr_sop  out  NUM_PORTS  start-of-packet pulse
- wr_vld  out  NUM_PORTS  data valid
- wr_data  out  NUM_PORTS x DATA_WIDTH  packed lanes
- wr_eop  out  NUM_PORTS  end-of-packet pulse
- busy  out  NUM_PORTS  channel not IDLE
- done  out  NUM_PORTS  one-cycle pulse when a command completes or abort finishes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On the first edge with rst=1, every channel goes to IDLE and all outputs are 0. This also applies mid-packet: the truncated packet is not completed. cmd_rdy reads 0 while rst=1.
- cmd_rdy: equals !busy[cmd_port] & !rst, combinational.
  - Command with cmd_count=0 is accepted as a no-op: no state change, no done.
  - Command to a busy channel is not accepted; the channel is unaffected.
- All wr_* outputs are registered.
- Per-channel FSM: IDLE -> SOP -> HDR -> PAY -> EOP -> GAP -> (SOP | IDLE).
  - Command accepted at edge T: SOP state, wr_sop=1 (wr_vld=0) in cycle T+1.
  - HDR: wr_vld=1, wr_data={len, prio, dest}, len in the MSBs.
  - PAY: cmd_len words, wr_vld=1. Word k (k = 0..len-1) is k in mode 0, or k ^ (pkt_seq << DATA_WIDTH/2) in mode 1, truncated to DATA_WIDTH. pkt_seq is the packet index within the command, starting at 0 and wrapping modulo 2^(DATA_WIDTH/2).
  - len=0: PAY is skipped; header-only packet.
  - EOP: wr_eop=1 and wr_vld=0 for one cycle, immediately after the last valid word.
  - GAP: cmd_gap idle cycles; gap=0 means the next SOP directly follows EOP. Then SOP if packets remain, else IDLE.
  - Entering IDLE: done=1 for one cycle, busy drops in that same cycle.
- Pause:
  - If pause[i] is sampled 1 at an edge, the next cycle carries no wr_sop or wr_vld on channel i, and the FSM holds state and word index.
  - Emission resumes on the cycle after pause is sampled 0.
  - EOP and GAP are not blocked by pause; GAP still counts down during pause.
- Abort:
  - abort[i] is sampled each edge and latched until IDLE.
  - Abort in IDLE: ignored.
  - Abort in GAP or before the first SOP is emitted: go to IDLE next edge.
  - Abort in HDR or PAY: the current packet completes including EOP, then IDLE.
  - A truncated packet is never emitted, except on reset.
- Simultaneous events:
  - A command accepted in the same cycle that channel j pulses done is legal when j != cmd_port.
  - Pause and abort together: abort latches, pause holds; the packet completes when pause releases.
- Counters: remaining-packet counter is CNT_WIDTH bits and decrements at each EOP. The word index is LEN_WIDTH bits.

Decomposition:
- Package hydra_pkt_gen_pkg holds:
  - the state enum (IDLE, SOP, HDR, PAY, EOP, GAP);
  - a packed header struct {len, prio, dest} with width localparams;
  - the cmd struct.
- One sub-module, hydra_pkt_gen_chan, holds one channel's FSM, counters and output registers.
- The top level decodes cmd_port, generates NUM_PORTS instances, and packs the outputs.

Test Plan:
- Reset mid-packet: cmd port 2, len 20, count 1; assert rst during PAY -> all outputs 0 next cycle, busy[2]=0, no done.
- Single packet: cmd port 0, dest 3, prio 4, len 4, count 1, gap 0, mode 0 -> sop at T+1; vld T+2..T+6 with data {4,4,3}, then 0,1,2,3; eop T+7; done T+8.
- Burst with gap: port 1, len 2, count 3, gap 2, mode 1 -> three packets; the second packet's payload is 0x0100, 0x0101; exactly 2 idle cycles between each eop and the next sop; cmd_rdy low throughout.
- Pause: port 3, len 8; raise pause[3] for 5 cycles mid-payload -> vld gap of 5 cycles starting one cycle after pause; word sequence unbroken 0..7; eop follows word 7.
- Abort: port 5, count 10, len 6; abort during packet 2's payload -> packet 2 completes with eop, then done, total exactly 2 eops.
- Header-only and no-op: len 0, count 2, gap 1 -> sop, header, eop, 1 idle, repeat; count 0 -> cmd_rdy=1, no activity, no done.

Source files
------------

// File: rtl/hydra_pkt_gen_pkg.sv
// rtl/hydra_pkt_gen_pkg.sv - shared types and default widths for the hydra packet generator
package hydra_pkt_gen_pkg;

  localparam int HDR_LEN_W  = 9;
  localparam int HDR_PRIO_W = 3;
  localparam int HDR_DEST_W = 4;
  localparam int HDR_W      = HDR_LEN_W + HDR_PRIO_W + HDR_DEST_W;
  localparam int CMD_CNT_W  = 16;
  localparam int CMD_GAP_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOP,
    ST_HDR,
    ST_PAY,
    ST_EOP,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [HDR_LEN_W-1:0]  len;
    logic [HDR_PRIO_W-1:0] prio;
    logic [HDR_DEST_W-1:0] dest;
  } hdr_t;

  typedef struct packed {
    hdr_t                 hdr;
    logic [CMD_CNT_W-1:0] count;
    logic [CMD_GAP_W-1:0] gap;
    logic                 mode;
  } cmd_t;

endpackage

// File: rtl/hydra_pkt_gen_chan.sv
// rtl/hydra_pkt_gen_chan.sv - one generator channel: FSM, counters and registered write-side outputs
module hydra_pkt_gen_chan
  import hydra_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 9,
  parameter int PRIO_WIDTH = 3,
  parameter int DEST_WIDTH = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DEST_WIDTH-1:0] i_dest,
  input  logic [PRIO_WIDTH-1:0] i_prio,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic [CNT_WIDTH-1:0]  i_count,
  input  logic [GAP_WIDTH-1:0]  i_gap,
  input  logic                  i_mode,
  input  logic                  i_abort,
  input  logic                  i_pause,
  output logic                  o_sop,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_eop,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int SEQ_W = DATA_WIDTH / 2;

  state_e                r_state;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [PRIO_WIDTH-1:0] r_prio;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [GAP_WIDTH-1:0]  r_gap;
  logic                  r_mode;
  logic [CNT_WIDTH-1:0]  r_remain;
  logic [SEQ_W-1:0]      r_seq;
  logic [LEN_WIDTH-1:0]  r_widx;
  logic [GAP_WIDTH-1:0]  r_gcnt;
  logic                  r_abort;
  logic                  r_sop, r_vld, r_eop, r_done;
  logic [DATA_WIDTH-1:0] r_data;

  state_e                w_ns;
  logic [LEN_WIDTH-1:0]  w_widx_n, w_widx_inc;
  logic [GAP_WIDTH-1:0]  w_gcnt_n;
  logic                  w_emit, w_abt, w_last;
  logic [DATA_WIDTH-1:0] w_pay, w_data_n;

  // A SOP/HDR/PAY cycle only advances if it actually went out (was not paused)
  always_comb begin
    w_emit     = r_sop | r_vld;
    w_abt      = r_abort | i_abort;
    w_last     = (r_remain == '0);
    w_widx_inc = r_widx + LEN_WIDTH'(1);
    w_ns       = r_state;
    w_widx_n   = r_widx;
    w_gcnt_n   = r_gcnt;
    case (r_state)
      ST_IDLE: if (i_start) w_ns = ST_SOP;
      ST_SOP: begin
        if (w_emit)     w_ns = ST_HDR;
        else if (w_abt) w_ns = ST_IDLE;
      end
      ST_HDR: begin
        if (w_emit) begin
          w_widx_n = '0;
          w_ns     = (r_len == '0) ? ST_EOP : ST_PAY;
        end
      end
      ST_PAY: begin
        if (w_emit) begin
          if (w_widx_inc == r_len) w_ns = ST_EOP;
          else                     w_widx_n = w_widx_inc;
        end
      end
      ST_EOP: begin
        w_gcnt_n = r_gap;
        if (w_abt || (w_last && r_gap == '0)) w_ns = ST_IDLE;
        else if (r_gap == '0)                 w_ns = ST_SOP;
        else                                  w_ns = ST_GAP;
      end
      ST_GAP: begin
        if (w_abt)                            w_ns = ST_IDLE;
        else if (r_gcnt == GAP_WIDTH'(1))     w_ns = w_last ? ST_IDLE : ST_SOP;
        else                                  w_gcnt_n = r_gcnt - GAP_WIDTH'(1);
      end
      default: w_ns = ST_IDLE;
    endcase

    w_pay = DATA_WIDTH'(w_widx_n);
    if (r_mode) w_pay = w_pay ^ (DATA_WIDTH'(r_seq) << SEQ_W);
    w_data_n = '0;
    if (!i_pause) begin
      if (w_ns == ST_HDR)      w_data_n = {r_len, r_prio, r_dest};
      else if (w_ns == ST_PAY) w_data_n = w_pay;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_dest   <= '0;
      r_prio   <= '0;
      r_len    <= '0;
      r_gap    <= '0;
      r_mode   <= 1'b0;
      r_remain <= '0;
      r_seq    <= '0;
      r_widx   <= '0;
      r_gcnt   <= '0;
      r_abort  <= 1'b0;
      r_sop    <= 1'b0;
      r_vld    <= 1'b0;
      r_eop    <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
    end else begin
      r_state <= w_ns;
      r_widx  <= w_widx_n;
      r_gcnt  <= w_gcnt_n;
      if (r_state == ST_IDLE && i_start) begin
        r_dest   <= i_dest;
        r_prio   <= i_prio;
        r_len    <= i_len;
        r_gap    <= i_gap;
        r_mode   <= i_mode;
        r_remain <= i_count;
        r_seq    <= '0;
      end else if (w_ns == ST_EOP) begin
        r_remain <= r_remain - CNT_WIDTH'(1);
        r_seq    <= r_seq + SEQ_W'(1);
      end
      r_abort <= (w_ns != ST_IDLE) && (r_state != ST_IDLE) && w_abt;
      r_sop   <= (w_ns == ST_SOP) && !i_pause;
      r_vld   <= ((w_ns == ST_HDR) || (w_ns == ST_PAY)) && !i_pause;
      r_eop   <= (w_ns == ST_EOP);
      r_done  <= (w_ns == ST_IDLE) && (r_state != ST_IDLE);
      r_data  <= w_data_n;
    end
  end

  assign o_sop  = r_sop;
  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_eop  = r_eop;
  assign o_done = r_done;
  assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/hydra_pkt_gen.sv
// rtl/hydra_pkt_gen.sv - multi-channel hydra write-side packet generator
module hydra_pkt_gen
  import hydra_pkt_gen_pkg::*;
#(
  parameter int  NUM_PORTS  = 16,
  parameter int  DATA_WIDTH = HDR_W,
  parameter int  LEN_WIDTH  = HDR_LEN_W,
  parameter int  PRIO_WIDTH = HDR_PRIO_W,
  parameter int  DEST_WIDTH = HDR_DEST_W,
  parameter int  CNT_WIDTH  = CMD_CNT_W,
  parameter int  GAP_WIDTH  = CMD_GAP_W,
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_vld,
  output logic                            cmd_rdy,
  input  logic [PORT_W-1:0]               cmd_port,
  input  logic [DEST_WIDTH-1:0]           cmd_dest,
  input  logic [PRIO_WIDTH-1:0]           cmd_prio,
  input  logic [LEN_WIDTH-1:0]            cmd_len,
  input  logic [CNT_WIDTH-1:0]            cmd_count,
  input  logic [GAP_WIDTH-1:0]            cmd_gap,
  input  logic                            cmd_mode,
  input  logic [NUM_PORTS-1:0]            abort,
  input  logic [NUM_PORTS-1:0]            pause,
  output logic [NUM_PORTS-1:0]            wr_sop,
  output logic [NUM_PORTS-1:0]            wr_vld,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_PORTS-1:0]            wr_eop,
  output logic [NUM_PORTS-1:0]            busy,
  output logic [NUM_PORTS-1:0]            done
);

  if ((LEN_WIDTH + PRIO_WIDTH + DEST_WIDTH) != DATA_WIDTH || NUM_PORTS < 1) begin : g_cfg_err
    $error("hydra_pkt_gen: header fields must exactly fill DATA_WIDTH and NUM_PORTS must be >= 1");
  end

  logic                 w_port_ok;
  logic                 w_accept;
  logic [NUM_PORTS-1:0] w_busy;

  // A zero-count command is handshaken but never reaches a channel
  assign w_port_ok = (int'(cmd_port) < NUM_PORTS);
  assign cmd_rdy   = w_port_ok && !w_busy[cmd_port] && !rst;
  assign w_accept  = cmd_vld && cmd_rdy && (cmd_count != '0);
  assign busy      = w_busy;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
    logic w_start;
    assign w_start = w_accept && (cmd_port == PORT_W'(i));

    hydra_pkt_gen_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH),
      .PRIO_WIDTH (PRIO_WIDTH),
      .DEST_WIDTH (DEST_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .GAP_WIDTH  (GAP_WIDTH)
    ) u_chan (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (w_start),
      .i_dest  (cmd_dest),
      .i_prio  (cmd_prio),
      .i_len   (cmd_len),
      .i_count (cmd_count),
      .i_gap   (cmd_gap),
      .i_mode  (cmd_mode),
      .i_abort (abort[i]),
      .i_pause (pause[i]),
      .o_sop   (wr_sop[i]),
      .o_vld   (wr_vld[i]),
      .o_data  (wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_eop   (wr_eop[i]),
      .o_busy  (w_busy[i]),
      .o_done  (done[i])
    );
  end

endmodule

// File: tb/tb_hydra_pkt_gen.sv
// tb/tb_hydra_pkt_gen.sv - scoreboard bench for hydra_pkt_gen
module tb_hydra_pkt_gen;

  localparam int NP = 16;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_vld, cmd_rdy, cmd_mode;
  logic [3:0]        cmd_port, cmd_dest, cmd_gap;
  logic [2:0]        cmd_prio;
  logic [8:0]        cmd_len;
  logic [15:0]       cmd_count;
  logic [NP-1:0]     abort, pause, wr_sop, wr_vld, wr_eop, busy, done;
  logic [NP*DW-1:0]  wr_data;

  hydra_pkt_gen #(
    .NUM_PORTS (NP),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (9),
    .PRIO_WIDTH(3),
    .DEST_WIDTH(4),
    .CNT_WIDTH (16),
    .GAP_WIDTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_port (cmd_port),
    .cmd_dest (cmd_dest),
    .cmd_prio (cmd_prio),
    .cmd_len  (cmd_len),
    .cmd_count(cmd_count),
    .cmd_gap  (cmd_gap),
    .cmd_mode (cmd_mode),
    .abort    (abort),
    .pause    (pause),
    .wr_sop   (wr_sop),
    .wr_vld   (wr_vld),
    .wr_data  (wr_data),
    .wr_eop   (wr_eop),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // one observed output beat: stamp = edge count preceding the cycle, flags = {sop, vld, eop, done}
  typedef struct packed {
    logic [31:0] stamp;
    logic [7:0]  port;
    logic [3:0]  flags;
    logic [15:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input int t, input int p, input logic [3:0] f, input logic [15:0] d);
    ev_t e;
    e.stamp = 32'(t);
    e.port  = 8'(p);
    e.flags = f;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // reference model of a command: events up to stamp 'cut' are queued; payload word stall_at
  // of the first packet is delayed by 'stall' cycles; t_done is the stamp of the done pulse
  task automatic push_cmd(input int p, input int t0, input int dest, input int prio, input int len,
                          input int npkt, input int gap, input int mode, input int stall_at,
                          input int stall, input int cut, output int t_done);
    int t;
    int d;
    t = t0;
    for (int s = 0; s < npkt; s++) begin
      if (t <= cut) push_ev(t, p, 4'b1000, 16'h0);
      t++;
      if (t <= cut) push_ev(t, p, 4'b0100, 16'((len << 7) | (prio << 4) | dest));
      t++;
      for (int k = 0; k < len; k++) begin
        if (s == 0 && k == stall_at) t += stall;
        d = (mode != 0) ? (k ^ ((s % 256) << 8)) : k;
        if (t <= cut) push_ev(t, p, 4'b0100, 16'(d));
        t++;
      end
      if (t <= cut) push_ev(t, p, 4'b0010, 16'h0);
      t += 1 + gap;
    end
    if (t <= cut) push_ev(t, p, 4'b0001, 16'h0);
    t_done = t;
  endtask

  task automatic send_cmd(input int p, input int dest, input int prio, input int len, input int cnt,
                          input int gap, input int mode, input logic exp_rdy, output int t_acc);
    @(negedge clk);
    cmd_vld   = 1'b1;
    cmd_port  = 4'(p);
    cmd_dest  = 4'(dest);
    cmd_prio  = 3'(prio);
    cmd_len   = 9'(len);
    cmd_count = 16'(cnt);
    cmd_gap   = 4'(gap);
    cmd_mode  = 1'(mode);
    #1;
    check("cmd_rdy_at_issue", 32'(cmd_rdy), 32'(exp_rdy));
    @(posedge clk);
    #1;
    t_acc   = cyc;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc <= t + 1) @(negedge clk);
  endtask

  // monitor: every non-idle beat must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (wr_sop[p] | wr_vld[p] | wr_eop[p] | done[p]) begin
          ev_t obs;
          ev_t ex;
          logic have;
          obs.stamp = 32'(cyc);
          obs.port  = 8'(p);
          obs.flags = {wr_sop[p], wr_vld[p], wr_eop[p], done[p]};
          obs.data  = wr_vld[p] ? wr_data[p*DW +: DW] : 16'h0;
          have = (exp_q.size() != 0);
          ex = '0;
          if (have) ex = exp_q.pop_front();
          n_tests++;
          assert (have && obs === ex) else begin
            n_fail++;
            $error("FAIL beat: observed t=%0d p=%0d f=%b d=%h expected t=%0d p=%0d f=%b d=%h (queued=%0d)",
                   obs.stamp, obs.port, obs.flags, obs.data, ex.stamp, ex.port, ex.flags, ex.data, have);
          end
        end
      end
    end
  end

  initial begin
    int t, td;
    rst = 1'b1; cmd_vld = 1'b0; cmd_port = '0; cmd_dest = '0; cmd_prio = '0; cmd_len = '0;
    cmd_count = '0; cmd_gap = '0; cmd_mode = 1'b0; abort = '0; pause = '0;
    repeat (3) @(negedge clk);
    check("rst_sop", 32'(wr_sop), 0);
    check("rst_vld", 32'(wr_vld), 0);
    check("rst_eop", 32'(wr_eop), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(|wr_data), 0);
    check("rst_rdy", 32'(cmd_rdy), 0);
    rst = 1'b0;
    #1;
    check("idle_rdy", 32'(cmd_rdy), 1);

    // single packet, mode 0
    send_cmd(0, 3, 4, 4, 1, 0, 0, 1'b1, t);
    push_cmd(0, t, 3, 4, 4, 1, 0, 0, 0, 0, 1 << 30, td);
    check("single_busy", 32'(busy[0]), 1);
    wait_to(td);
    check("single_idle", 32'(busy[0]), 0);
    check("single_q", 32'(exp_q.size()), 0);

    // burst with gap, mode 1; a second command to the busy channel must stay refused
    send_cmd(1, 7, 2, 2, 3, 2, 1, 1'b1, t);
    push_cmd(1, t, 7, 2, 2, 3, 2, 1, 0, 0, 1 << 30, td);
    cmd_port = 4'd1; cmd_count = 16'd5; cmd_vld = 1'b1;
    while (cyc < td) begin
      check("burst_rdy_low", 32'(cmd_rdy), 0);
      @(negedge clk);
    end
    cmd_vld = 1'b0;
    wait_to(td);
    check("burst_q", 32'(exp_q.size()), 0);

    // pause five cycles during the payload
    send_cmd(3, 1, 1, 8, 1, 0, 0, 1'b1, t);
    push_cmd(3, t, 1, 1, 8, 1, 0, 0, 2, 5, 1 << 30, td);
    repeat (4) @(negedge clk);
    pause[3] = 1'b1;
    repeat (5) @(negedge clk);
    pause[3] = 1'b0;
    wait_to(td);
    check("pause_q", 32'(exp_q.size()), 0);

    // abort during the second packet's payload: exactly two packets then done
    send_cmd(5, 2, 7, 6, 10, 0, 1, 1'b1, t);
    push_cmd(5, t, 2, 7, 6, 2, 0, 1, 0, 0, 1 << 30, td);
    repeat (13) @(negedge clk);
    abort[5] = 1'b1;
    @(negedge clk);
    abort[5] = 1'b0;
    wait_to(td);
    check("abort_idle", 32'(busy[5]), 0);
    check("abort_q", 32'(exp_q.size()), 0);

    // header-only packets
    send_cmd(4, 9, 2, 0, 2, 1, 0, 1'b1, t);
    push_cmd(4, t, 9, 2, 0, 2, 1, 0, 0, 0, 1 << 30, td);
    wait_to(td);
    check("hdronly_q", 32'(exp_q.size()), 0);

    // zero-count command is a no-op
    send_cmd(6, 1, 1, 3, 0, 0, 0, 1'b1, t);
    repeat (6) @(negedge clk);
    check("noop_busy", 32'(busy), 0);
    check("noop_q", 32'(exp_q.size()), 0);

    // reset in the middle of a long payload truncates the packet silently
    send_cmd(2, 1, 1, 20, 1, 0, 0, 1'b1, t);
    push_cmd(2, t, 1, 1, 20, 1, 0, 0, 0, 0, t + 5, td);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    cmd_port = 4'd2;
    @(negedge clk);
    check("midrst_vld", 32'(wr_vld), 0);
    check("midrst_sop", 32'(wr_sop), 0);
    check("midrst_busy2", 32'(busy[2]), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_rdy", 32'(cmd_rdy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_quiet", 32'(busy), 0);
    check("final_q", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
